wb_arb: RTL and testbench

Writeback arbiter sharing the single register-file write port between the integer pipe (IP) and the load/store pipe (LSP). Accepts completed results over valid/ready handshakes, selects one writer per cycle by a starvation-guarded fixed priority, and drives a registered write/scoreboard-clear port into the issue stage. Sits between the FU result outputs and the issue stage's regfile and scoreboard.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_arb_sel.sv | 58 +++++
 rtl/wb_arb.sv | 114 +++++++++++
 tb/tb_wb_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared grant encoding, payload widths and helpers for the
// writeback arbiter. Build option WB_ARB_RR_EN selects round-robin arbitration.
package wb_arb_pkg;

    localparam int WB_DST_W = 5;
    localparam int WB_VAL_W = 64;
    localparam int WB_PC_W  = 64;
    localparam int WB_CNT_W = 4;    // holds STARVE_LIMIT up to 15

    localparam logic WB_GNT_IP  = 1'b0;
    localparam logic WB_GNT_LSP = 1'b1;

    typedef struct packed {
        logic [WB_DST_W-1:0] dst;
        logic [WB_VAL_W-1:0] value;
        logic [WB_PC_W-1:0]  pc;
    } wb_pld_t;

    // Saturating increment used by the starvation counter
    function automatic logic [WB_CNT_W-1:0] sat_inc(input logic [WB_CNT_W-1:0] v,
                                                    input logic [WB_CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_arb_sel.sv
// wb_arb_sel: combinational grant/accept selection for the writeback port.
// WB_ARB_RR_EN: alternate on contention using last_grant; otherwise LSP has
// priority unless IP is flagged as starved.
module wb_arb_sel
    import wb_arb_pkg::*;
(
    input  logic ip_valid,
    input  logic ip_wb_en,
    input  logic lsp_valid,
    input  logic lsp_wb_en,
    input  logic hold,
    input  logic ip_starved,
    input  logic last_grant,
    output logic gnt_vld,
    output logic gnt,
    output logic ip_acc,
    output logic lsp_acc
);

    logic ip_req, lsp_req;
    assign ip_req  = ip_valid && ip_wb_en;
    assign lsp_req = lsp_valid && lsp_wb_en;

`ifdef WB_ARB_RR_EN
    logic unused_starved;
    assign unused_starved = ip_starved;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick one writer; non-writing transfers ride along whenever not held
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = WB_GNT_IP;
        ip_acc  = 1'b0;
        lsp_acc = 1'b0;
        if (!hold) begin
            if (ip_req && lsp_req) begin
                gnt_vld = 1'b1;
`ifdef WB_ARB_RR_EN
                gnt = (last_grant == WB_GNT_IP) ? WB_GNT_LSP : WB_GNT_IP;
`else
                gnt = ip_starved ? WB_GNT_IP : WB_GNT_LSP;
`endif
            end else if (ip_req) begin
                gnt_vld = 1'b1;
                gnt     = WB_GNT_IP;
            end else if (lsp_req) begin
                gnt_vld = 1'b1;
                gnt     = WB_GNT_LSP;
            end
            ip_acc  = (ip_valid && !ip_wb_en) || (gnt_vld && gnt == WB_GNT_IP);
            lsp_acc = (lsp_valid && !lsp_wb_en) || (gnt_vld && gnt == WB_GNT_LSP);
        end
    end

endmodule

// File: rtl/wb_arb.sv
// wb_arb: writeback arbiter sharing the regfile write port between IP and LSP.
// Holds the starvation counter, last grant and the registered write port.
// Build option WB_ARB_RR_EN: round-robin, starvation counter compiled out.
module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_hold,
    input  logic                ip_wb_valid,
    output logic                ip_wb_ready,
    input  logic                ip_wb_wb_en,
    input  logic [WB_DST_W-1:0] ip_wb_dst,
    input  logic [WB_VAL_W-1:0] ip_wb_result,
    input  logic [WB_PC_W-1:0]  ip_wb_pc,
    input  logic                lsp_wb_valid,
    output logic                lsp_wb_ready,
    input  logic                lsp_wb_wb_en,
    input  logic [WB_DST_W-1:0] lsp_wb_dst,
    input  logic [WB_VAL_W-1:0] lsp_wb_result,
    input  logic [WB_PC_W-1:0]  lsp_wb_pc,
    output logic                wb_rf_en,
    output logic [WB_DST_W-1:0] wb_rf_dst,
    output logic [WB_VAL_W-1:0] wb_rf_value,
    output logic [WB_PC_W-1:0]  wb_rf_pc,
    output logic                wb_sb_clr,
    output logic                wb_ip_starved
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_arb: STARVE_LIMIT must be in 1..15");
    end

    logic    gnt_vld, gnt, ip_acc, lsp_acc;
    logic    last_grant, ip_starved;
    wb_pld_t ip_pld, lsp_pld, win_pld, wb_q;
    logic    wb_en_q;

    assign ip_pld  = '{dst: ip_wb_dst,  value: ip_wb_result,  pc: ip_wb_pc};
    assign lsp_pld = '{dst: lsp_wb_dst, value: lsp_wb_result, pc: lsp_wb_pc};
    assign win_pld = (gnt == WB_GNT_LSP) ? lsp_pld : ip_pld;

    wb_arb_sel u_sel (
        .ip_valid   (ip_wb_valid),
        .ip_wb_en   (ip_wb_wb_en),
        .lsp_valid  (lsp_wb_valid),
        .lsp_wb_en  (lsp_wb_wb_en),
        .hold       (wb_hold),
        .ip_starved (ip_starved),
        .last_grant (last_grant),
        .gnt_vld    (gnt_vld),
        .gnt        (gnt),
        .ip_acc     (ip_acc),
        .lsp_acc    (lsp_acc)
    );

    // Nothing is acknowledged while reset is asserted
    assign ip_wb_ready  = ip_acc && !rst;
    assign lsp_wb_ready = lsp_acc && !rst;

`ifdef WB_ARB_RR_EN
    assign ip_starved = 1'b0;
`else
    localparam logic [WB_CNT_W-1:0] LIMIT_C = WB_CNT_W'(STARVE_LIMIT);
    logic [WB_CNT_W-1:0] starve_cnt;
    logic                ip_req;
    assign ip_req = ip_wb_valid && ip_wb_wb_en;

    // Count consecutive IP denials lost to LSP; frozen while held
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!wb_hold) begin
            if (ip_req && gnt_vld && gnt == WB_GNT_LSP)
                starve_cnt <= sat_inc(starve_cnt, LIMIT_C);
            else
                starve_cnt <= '0;
        end
    end

    assign ip_starved = (starve_cnt == LIMIT_C);
`endif

    assign wb_ip_starved = ip_starved;

    // Remember the most recent write-port winner for round-robin
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= WB_GNT_IP;
        else if (gnt_vld)
            last_grant <= gnt;
    end

    // Registered write port; x0 writes are accepted but never strobed
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q <= 1'b0;
            wb_q    <= '0;
        end else begin
            wb_en_q <= gnt_vld && (win_pld.dst != '0);
            if (gnt_vld)
                wb_q <= win_pld;
        end
    end

    assign wb_rf_en    = wb_en_q;
    assign wb_sb_clr   = wb_en_q;
    assign wb_rf_dst   = wb_q.dst;
    assign wb_rf_value = wb_q.value;
    assign wb_rf_pc    = wb_q.pc;

endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: scoreboard bench for wb_arb. A stimulus process drives queued
// transactions per port and a transaction-level model predicts readies and
// the write stream; a monitor pops expected writes each cycle and compares.
module tb_wb_arb;

    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_hold = 1'b0;
    logic        ip_wb_valid = 1'b0, ip_wb_wb_en = 1'b0;
    logic [4:0]  ip_wb_dst = '0;
    logic [63:0] ip_wb_result = '0, ip_wb_pc = '0;
    logic        lsp_wb_valid = 1'b0, lsp_wb_wb_en = 1'b0;
    logic [4:0]  lsp_wb_dst = '0;
    logic [63:0] lsp_wb_result = '0, lsp_wb_pc = '0;
    logic        ip_wb_ready, lsp_wb_ready;
    logic        wb_rf_en, wb_sb_clr, wb_ip_starved;
    logic [4:0]  wb_rf_dst;
    logic [63:0] wb_rf_value, wb_rf_pc;

    always #5 clk = ~clk;

    wb_arb #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst), .wb_hold(wb_hold),
        .ip_wb_valid(ip_wb_valid), .ip_wb_ready(ip_wb_ready), .ip_wb_wb_en(ip_wb_wb_en),
        .ip_wb_dst(ip_wb_dst), .ip_wb_result(ip_wb_result), .ip_wb_pc(ip_wb_pc),
        .lsp_wb_valid(lsp_wb_valid), .lsp_wb_ready(lsp_wb_ready), .lsp_wb_wb_en(lsp_wb_wb_en),
        .lsp_wb_dst(lsp_wb_dst), .lsp_wb_result(lsp_wb_result), .lsp_wb_pc(lsp_wb_pc),
        .wb_rf_en(wb_rf_en), .wb_rf_dst(wb_rf_dst), .wb_rf_value(wb_rf_value),
        .wb_rf_pc(wb_rf_pc), .wb_sb_clr(wb_sb_clr), .wb_ip_starved(wb_ip_starved)
    );

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  dst;
        logic [63:0] result;
        logic [63:0] pc;
    } txn_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  dst;
        logic [63:0] value;
        logic [63:0] pc;
    } wr_t;

    txn_t ip_q[$], lsp_q[$];
    txn_t ip_cur = '0, lsp_cur = '0;
    bit   ip_busy = 0, lsp_busy = 0;
    wr_t  exp_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: consecutive IP losses and who last owned the write port
    int m_starve = 0;
    bit m_last_lsp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit en, input int dst, input logic [63:0] res, input logic [63:0] pc);
        txn_t t;
        t.wb_en = en; t.dst = 5'(dst); t.result = res; t.pc = pc;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        t.wb_en  = ($urandom_range(0, 9) != 0);
        t.dst    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        t.result = {$urandom, $urandom};
        t.pc     = {32'h0, $urandom};
        return t;
    endfunction

    // Monitor: every cycle compare the write port against the oldest prediction
    always @(negedge clk) begin : mon
        wr_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_rf_en", 64'(wb_rf_en), 64'(e.en));
            chk("wb_sb_clr", 64'(wb_sb_clr), 64'(e.en));
            if (e.en) begin
                chk("wb_rf_dst", 64'(wb_rf_dst), 64'(e.dst));
                chk("wb_rf_value", wb_rf_value, e.value);
                chk("wb_rf_pc", wb_rf_pc, e.pc);
            end
        end
    end

    // One cycle: present port heads, predict accepts/write, check readies
    task automatic step(input bit h, input bit r);
        bit   ip_req, lsp_req, g_ip, g_lsp, a_ip, a_lsp, win_lsp;
        txn_t w;
        wr_t  e;
        @(negedge clk);
        if (!ip_busy && ip_q.size() > 0) begin ip_cur = ip_q.pop_front(); ip_busy = 1; end
        if (!lsp_busy && lsp_q.size() > 0) begin lsp_cur = lsp_q.pop_front(); lsp_busy = 1; end
        rst = r; wb_hold = h;
        ip_wb_valid  = ip_busy;  ip_wb_wb_en  = ip_cur.wb_en;  ip_wb_dst  = ip_cur.dst;
        ip_wb_result = ip_cur.result; ip_wb_pc = ip_cur.pc;
        lsp_wb_valid = lsp_busy; lsp_wb_wb_en = lsp_cur.wb_en; lsp_wb_dst = lsp_cur.dst;
        lsp_wb_result = lsp_cur.result; lsp_wb_pc = lsp_cur.pc;
        #1;
        ip_req  = ip_busy && ip_cur.wb_en;
        lsp_req = lsp_busy && lsp_cur.wb_en;
        g_ip = 0; g_lsp = 0; a_ip = 0; a_lsp = 0;
        if (!r && !h) begin
            if (ip_req && lsp_req) begin
`ifdef WB_ARB_RR_EN
                win_lsp = !m_last_lsp;
`else
                win_lsp = (m_starve != STARVE_LIMIT);
`endif
                g_lsp = win_lsp; g_ip = !win_lsp;
            end else begin
                g_ip = ip_req; g_lsp = lsp_req;
            end
            a_ip  = g_ip  || (ip_busy && !ip_cur.wb_en);
            a_lsp = g_lsp || (lsp_busy && !lsp_cur.wb_en);
        end
        chk("ip_wb_ready", 64'(ip_wb_ready), 64'(a_ip));
        chk("lsp_wb_ready", 64'(lsp_wb_ready), 64'(a_lsp));
`ifdef WB_ARB_RR_EN
        chk("wb_ip_starved", 64'(wb_ip_starved), 64'(0));
`else
        chk("wb_ip_starved", 64'(wb_ip_starved), 64'(m_starve == STARVE_LIMIT));
`endif
        e = '0;
        if (g_ip || g_lsp) begin
            w = g_lsp ? lsp_cur : ip_cur;
            e.en = (w.dst != 0); e.dst = w.dst; e.value = w.result; e.pc = w.pc;
        end
        exp_q.push_back(e);
        if (r) begin
            m_starve = 0; m_last_lsp = 0;
        end else if (!h) begin
            if (ip_req && g_lsp) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
            else m_starve = 0;
            if (g_ip) m_last_lsp = 0;
            else if (g_lsp) m_last_lsp = 1;
        end
        if (a_ip) ip_busy = 0;
        if (a_lsp) lsp_busy = 0;
    endtask

    initial begin
        int n;
        // Reset state
        step(0, 1);
        step(0, 1);
        chk("rst_rf_dst", 64'(wb_rf_dst), 64'(0));
        chk("rst_rf_value", wb_rf_value, 64'(0));
        chk("rst_rf_pc", wb_rf_pc, 64'(0));

        // IP only, three back-to-back writes to x5
        for (int i = 0; i < 3; i++) ip_q.push_back(mk(1, 5, 64'h1234, 64'h100 + 64'(4 * i)));
        for (int i = 0; i < 5; i++) step(0, 0);

        // Both streaming: starvation pattern (or alternation under round-robin)
        for (int i = 0; i < 8; i++) begin
            ip_q.push_back(mk(1, 1 + i, 64'hA000 + 64'(i), 64'h200 + 64'(i)));
            lsp_q.push_back(mk(1, 10 + i, 64'hB000 + 64'(i), 64'h300 + 64'(i)));
        end
        for (int i = 0; i < 18; i++) step(0, 0);

        // Non-writing IP alongside an LSP write to x7
        ip_q.push_back(mk(0, 9, 64'hDEAD, 64'h400));
        lsp_q.push_back(mk(1, 7, 64'h7777, 64'h404));
        for (int i = 0; i < 3; i++) step(0, 0);

        // LSP write to x0: accepted, never strobed
        lsp_q.push_back(mk(1, 0, 64'h5555, 64'h500));
        for (int i = 0; i < 3; i++) step(0, 0);

        // Hold with both requesting, then reset while a write is pending
        for (int i = 0; i < 3; i++) begin
            ip_q.push_back(mk(1, 20 + i, 64'hC000 + 64'(i), 64'h600 + 64'(i)));
            lsp_q.push_back(mk(1, 3, 64'hD000 + 64'(i), 64'h700 + 64'(i)));
        end
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 1);
        for (int i = 0; i < 10; i++) step(0, 0);

        // Randomized traffic with occasional hold and reset
        for (int i = 0; i < 400; i++) begin
            if (ip_q.size() == 0 && $urandom_range(0, 3) != 0) ip_q.push_back(rnd_txn());
            if (lsp_q.size() == 0 && $urandom_range(0, 3) != 0) lsp_q.push_back(rnd_txn());
            step($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        // Drain, bounded
        n = 0;
        while ((ip_busy || lsp_busy || ip_q.size() > 0 || lsp_q.size() > 0) && n < 100) begin
            step(0, 0);
            n++;
        end
        chk("drain_timeout", 64'(n < 100), 64'(1));
        step(0, 0);
        @(negedge clk);
        #2;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
